// File: rtl/pragmatic_weight_encoder.sv
// pragmatic_weight_encoder: turns one group of signed weights into the
// per-beat essential-bit control stream for the Pragmatic 8-lane MAC array.
// Each beat fires at most one pending magnitude bit per lane, expressed as
// shift_2nd_sel (group base) + shift_1st_sel (lane offset).
// Optional build macro: PRAGMATIC_ENC_STATS_EN adds stat_beats / stat_bits.
module pragmatic_weight_encoder #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             w_valid,
  output logic                             w_ready,
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0] w_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [2*VEC_LENGTH-1:0]          shift_1st_sel,
  output logic [VEC_LENGTH-1:0]            shift_1st_en,
  output logic [1:0]                       shift_2nd_sel,
  output logic                             shift_2nd_en,
  output logic [VEC_LENGTH-1:0]            is_neg,
  output logic                             out_last
`ifdef PRAGMATIC_ENC_STATS_EN
  ,
  output logic [31:0]                      stat_beats,
  output logic [31:0]                      stat_bits
`endif
);

  localparam int MW = DATA_WIDTH - 1;   // magnitude width
  localparam int PW = $clog2(MW);       // bit-position width

  typedef enum logic {S_IDLE, S_ENCODE} state_e;

  state_e                           state_q, state_d;
  logic [VEC_LENGTH-1:0][MW-1:0]    pend_q, pend_d;
  logic [VEC_LENGTH-1:0]            neg_q, neg_d;

  logic [VEC_LENGTH-1:0][MW-1:0]    pend_clr;
  logic [VEC_LENGTH-1:0][MW-1:0]    mag_ld;
  logic [VEC_LENGTH-1:0]            neg_ld;
  logic [VEC_LENGTH-1:0]            lane_nz;
  logic [PW-1:0]                    low [VEC_LENGTH];
  logic [PW-1:0]                    p_min, base;
  logic                             any_nz;
  logic [PW:0]                      diff;
  logic [VEC_LENGTH-1:0]            en_c;
  logic [2*VEC_LENGTH-1:0]          sel_c;
  logic [DATA_WIDTH-1:0]            w_lane, neg_w;
  logic                             enc, fire, last_c, load;

`ifdef PRAGMATIC_ENC_STATS_EN
  logic [31:0] stat_beats_q, stat_beats_d, stat_bits_q, stat_bits_d;
  logic [31:0] pop;
`endif

  // Per-beat selection: lowest pending bit per lane, group base, lane enables and clears
  always_comb begin
    lane_nz  = '0;
    any_nz   = 1'b0;
    p_min    = '0;
    en_c     = '0;
    sel_c    = '0;
    diff     = '0;
    pend_clr = pend_q;
    for (int unsigned i = 0; i < VEC_LENGTH; i++) begin
      lane_nz[i] = |pend_q[i];
      low[i]     = '0;
      // descending scan so the final write is the lowest set bit
      for (int unsigned k = 0; k < MW; k++) begin
        if (pend_q[i][MW-1-k]) low[i] = PW'(MW-1-k);
      end
      if (lane_nz[i] && (!any_nz || low[i] < p_min)) begin
        p_min  = low[i];
        any_nz = 1'b1;
      end
    end
    base = (p_min > PW'(3)) ? PW'(3) : p_min;
    for (int unsigned i = 0; i < VEC_LENGTH; i++) begin
      if (lane_nz[i] && ({1'b0, low[i]} <= {1'b0, base} + (PW+1)'(3))) begin
        en_c[i]            = 1'b1;
        diff               = {1'b0, low[i]} - {1'b0, base};
        sel_c[2*i +: 2]    = diff[1:0];
        pend_clr[i][low[i]] = 1'b0;
      end
    end
  end

  // Group load: signed weights to sign-magnitude, most-negative value saturates
  always_comb begin
    mag_ld = '0;
    neg_ld = '0;
    w_lane = '0;
    neg_w  = '0;
    for (int unsigned i = 0; i < VEC_LENGTH; i++) begin
      w_lane    = w_in[i*DATA_WIDTH +: DATA_WIDTH];
      neg_w     = ~w_lane + DATA_WIDTH'(1);
      neg_ld[i] = w_lane[DATA_WIDTH-1];
      if (!w_lane[DATA_WIDTH-1])  mag_ld[i] = w_lane[MW-1:0];
      else if (w_lane[MW-1:0] == '0) mag_ld[i] = '1;
      else                        mag_ld[i] = neg_w[MW-1:0];
    end
  end

  // Handshakes and next-state: last beat may hand over directly to a new group
  always_comb begin
    enc     = (state_q == S_ENCODE);
    fire    = enc && out_ready;
    last_c  = enc && (pend_clr == '0);
    w_ready = !enc || (last_c && out_ready);
    load    = w_valid && w_ready;
    state_d = state_q;
    pend_d  = pend_q;
    neg_d   = neg_q;
    if (fire) begin
      pend_d = pend_clr;
      if (last_c) state_d = S_IDLE;
    end
    if (load) begin
      pend_d  = mag_ld;
      neg_d   = neg_ld;
      state_d = S_ENCODE;
    end
  end

  // Control beat outputs, combinational from the pending registers
  always_comb begin
    out_valid     = enc;
    out_last      = last_c;
    shift_1st_en  = en_c;
    shift_1st_sel = sel_c;
    shift_2nd_sel = base[1:0];
    shift_2nd_en  = |en_c;
    is_neg        = enc ? neg_q : '0;
  end

`ifdef PRAGMATIC_ENC_STATS_EN
  // Wrapping beat / fired-bit counters
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < VEC_LENGTH; i++) pop = pop + 32'(en_c[i]);
    stat_beats_d = stat_beats_q;
    stat_bits_d  = stat_bits_q;
    if (fire) begin
      stat_beats_d = stat_beats_q + 32'd1;
      stat_bits_d  = stat_bits_q + pop;
    end
  end
  assign stat_beats = stat_beats_q;
  assign stat_bits  = stat_bits_q;
`endif

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      neg_q   <= '0;
`ifdef PRAGMATIC_ENC_STATS_EN
      stat_beats_q <= '0;
      stat_bits_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      neg_q   <= neg_d;
`ifdef PRAGMATIC_ENC_STATS_EN
      stat_beats_q <= stat_beats_d;
      stat_bits_q  <= stat_bits_d;
`endif
    end
  end

endmodule

// File: tb/tb_pragmatic_weight_encoder.sv
// Testbench for pragmatic_weight_encoder: directed and random weight groups
// compared beat by beat against a sign-magnitude / essential-bit model.
module tb_pragmatic_weight_encoder;
  localparam int DW = 8;
  localparam int VL = 8;

  logic clk = 1'b0;
  logic reset, w_valid, w_ready, out_valid, out_ready, shift_2nd_en, out_last;
  logic [VL*DW-1:0] w_in;
  logic [2*VL-1:0]  shift_1st_sel;
  logic [VL-1:0]    shift_1st_en, is_neg;
  logic [1:0]       shift_2nd_sel;
`ifdef PRAGMATIC_ENC_STATS_EN
  logic [31:0] stat_beats, stat_bits;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pragmatic_weight_encoder #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) dut (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready), .w_in(w_in),
    .out_valid(out_valid), .out_ready(out_ready), .shift_1st_sel(shift_1st_sel),
    .shift_1st_en(shift_1st_en), .shift_2nd_sel(shift_2nd_sel),
    .shift_2nd_en(shift_2nd_en), .is_neg(is_neg), .out_last(out_last)
`ifdef PRAGMATIC_ENC_STATS_EN
    , .stat_beats(stat_beats), .stat_bits(stat_bits)
`endif
  );

  // observed vector: {w_ready, out_valid, out_last, 2nd_en, 2nd_sel, is_neg, 1st_en, 1st_sel}
  logic [37:0] obs;
  assign obs = {w_ready, out_valid, out_last, shift_2nd_en, shift_2nd_sel,
                is_neg, shift_1st_en, shift_1st_sel};

  logic [37:0] idle_vec;
  assign idle_vec = {1'b1, 37'd0};

  logic [37:0] exp_q[$];
  int          model_bits;

  function automatic int lowest(input int m);
    for (int p = 0; p < DW-1; p++) if (m[p]) return p;
    return DW;
  endfunction

  // Expected beat list for a group, assuming out_ready=1 on every beat
  task automatic build_model(input logic [VL*DW-1:0] w);
    int mag[VL];
    logic [VL-1:0]   neg, en;
    logic [2*VL-1:0] sel;
    int pmin, base, lp, v;
    logic last;
    exp_q.delete();
    model_bits = 0;
    for (int i = 0; i < VL; i++) begin
      v      = int'($signed(w[i*DW +: DW]));
      neg[i] = (v < 0);
      mag[i] = (v < 0) ? -v : v;
      if (mag[i] > (1 << (DW-1)) - 1) mag[i] = (1 << (DW-1)) - 1;
    end
    do begin
      pmin = DW;
      for (int i = 0; i < VL; i++) if (lowest(mag[i]) < pmin) pmin = lowest(mag[i]);
      base = (pmin == DW) ? 0 : ((pmin < 3) ? pmin : 3);
      en = '0;
      sel = '0;
      for (int i = 0; i < VL; i++) begin
        lp = lowest(mag[i]);
        if (lp < DW && lp <= base + 3) begin
          en[i] = 1'b1;
          sel[2*i +: 2] = 2'(lp - base);
          mag[i] = mag[i] - (1 << lp);
          model_bits++;
        end
      end
      last = 1'b1;
      for (int i = 0; i < VL; i++) if (mag[i] != 0) last = 1'b0;
      exp_q.push_back({last, 1'b1, last, |en, 2'(base), neg, en, sel});
    end while (!last);
  endtask

  task automatic test_reset();
    reset = 1'b0; w_valid = 1'b0; out_ready = 1'b0; w_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== idle_vec) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", obs, idle_vec);
    end
  endtask

  task automatic test_encode();
    logic [VL*DW-1:0] tbl[4];
    logic [VL*DW-1:0] w;
    logic [7:0] b8;
    int r;
    tbl[0] = '0;
    tbl[1] = 64'h0000_0000_0000_0005;
    tbl[2] = 64'h0000_0000_0000_C07F;
    tbl[3] = 64'h0000_0000_0080_0000;
    for (int n = 0; n < 24; n++) begin
      if (n < 4) w = tbl[n];
      else begin
        for (int i = 0; i < VL; i++) begin
          r = int'($urandom_range(0, 4));
          b8 = (r == 0) ? 8'h00 : (r == 1) ? 8'h80 : 8'($urandom);
          w[i*DW +: DW] = b8;
        end
      end
      build_model(w);
      @(negedge clk);
      w_valid = 1'b1; w_in = w; out_ready = 1'b1;
      #1;
      checks++;
      if (obs !== idle_vec) begin
        errors++;
        $display("FAIL encode_idle group %0d got %h exp %h", n, obs, idle_vec);
      end
      @(negedge clk);
      w_valid = 1'b0; w_in = {$urandom, $urandom};
      for (int b = 0; b < exp_q.size(); b++) begin
        #1;
        checks++;
        if (obs !== exp_q[b]) begin
          errors++;
          $display("FAIL encode group %0d w %h beat %0d got %h exp %h", n, w, b, obs, exp_q[b]);
        end
        @(negedge clk);
      end
      #1;
      checks++;
      if (obs !== idle_vec) begin
        errors++;
        $display("FAIL encode_return_idle group %0d got %h exp %h", n, obs, idle_vec);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [37:0] e;
    build_model(64'h0000_0000_0000_C07F);
    @(negedge clk);
    w_valid = 1'b1; w_in = 64'h0000_0000_0000_C07F; out_ready = 1'b1;
    @(negedge clk);
    w_valid = 1'b0;
    for (int b = 0; b < exp_q.size(); b++) begin
      for (int s = 0; s < ((b == 3) ? 4 : 1); s++) begin
        out_ready = !(b == 3 && s < 3);
        #1;
        e = exp_q[b];
        e[37] = e[37] & out_ready;
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL backpressure beat %0d stall %0d got %h exp %h", b, s, obs, e);
        end
        @(negedge clk);
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [37:0] ea, eb;
    ea = {1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 8'h01, 16'h0000};
    eb = {1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 8'h00, 8'h01, 16'h0000};
    @(negedge clk);
    w_valid = 1'b1; w_in = 64'd1; out_ready = 1'b1;
    @(negedge clk);
    w_in = 64'd2;
    #1;
    checks++;
    if (obs !== ea) begin
      errors++;
      $display("FAIL b2b_first got %h exp %h", obs, ea);
    end
    @(negedge clk);
    w_valid = 1'b0;
    #1;
    checks++;
    if (obs !== eb) begin
      errors++;
      $display("FAIL b2b_second_no_bubble got %h exp %h", obs, eb);
    end
    @(negedge clk);
    #1;
    checks++;
    if (obs !== idle_vec) begin
      errors++;
      $display("FAIL b2b_idle got %h exp %h", obs, idle_vec);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    w_valid = 1'b1; w_in = 64'h0000_0000_0000_807F; out_ready = 1'b1;
    @(negedge clk);
    w_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== idle_vec) begin
      errors++;
      $display("FAIL mid_reset got %h exp %h", obs, idle_vec);
    end
    build_model(64'd5);
    @(negedge clk);
    w_valid = 1'b1; w_in = 64'd5;
    @(negedge clk);
    w_valid = 1'b0;
    for (int b = 0; b < exp_q.size(); b++) begin
      #1;
      checks++;
      if (obs !== exp_q[b]) begin
        errors++;
        $display("FAIL post_reset beat %0d got %h exp %h", b, obs, exp_q[b]);
      end
      @(negedge clk);
    end
  endtask

`ifdef PRAGMATIC_ENC_STATS_EN
  task automatic test_stats();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    build_model(64'h0000_0000_0000_C07F);
    w_valid = 1'b1; w_in = 64'h0000_0000_0000_C07F; out_ready = 1'b1;
    @(negedge clk);
    w_valid = 1'b0;
    repeat (exp_q.size()) @(negedge clk);
    #1;
    checks++;
    if (stat_beats !== 32'(exp_q.size()) || stat_bits !== 32'(model_bits)) begin
      errors++;
      $display("FAIL stats got %0d/%0d exp %0d/%0d", stat_beats, stat_bits, exp_q.size(), model_bits);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_encode();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
`ifdef PRAGMATIC_ENC_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
